// File: rtl/adc082s101_responder.sv
// ADC082S101 serial-port responder: serves 8-bit samples from two channels
// to an SPI initiator and decodes its control byte, all on oversampled lines.
module adc082s101_responder #(
    parameter int BYTE_W      = 8,
    parameter int FRAME_W     = 16,
    parameter int LEAD_ZEROS  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ser_clk,
    input  logic              CSN,
    input  logic              SDI,
    input  logic [BYTE_W-1:0] CH0_DATA,
    input  logic [BYTE_W-1:0] CH1_DATA,
    output logic              SDO,
    output logic              SDO_OE,
    output logic [BYTE_W-1:0] CTRL_WORD,
    output logic              CTRL_VALID,
    output logic              FRAME_DONE,
    output logic              FRAME_ERR,
    output logic              ACTIVE_CH
);

    localparam int TRAIL = FRAME_W - LEAD_ZEROS - BYTE_W;
    localparam int CW    = $clog2(FRAME_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_W - 1);
    localparam logic [CW-1:0] CTRL_BITS = CW'(BYTE_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, ABORT} state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] csn_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic [SYNC_STAGES-1:0] warm_sr;
    logic [1:0]             clk_hist;

    state_t              state;
    logic [CW-1:0]       bit_ctr;
    logic [FRAME_W-1:0]  frame_sr;
    logic [BYTE_W-1:0]   ctrl_sr;
    logic                armed;
    logic                reload_pend;

    logic                csn_s;
    logic                sdi_s;
    logic                warm;
    logic                rise;
    logic                fall;
    logic [FRAME_W-1:0]  load_word;
    logic [FRAME_W-1:0]  reload_word;

    function automatic logic [FRAME_W-1:0] frame_of(input logic [BYTE_W-1:0] s);
        frame_of = {{(FRAME_W - BYTE_W){1'b0}}, s} << TRAIL;
    endfunction

    assign csn_s       = csn_sync[SYNC_STAGES-1];
    assign sdi_s       = sdi_sync[SYNC_STAGES-1];
    assign warm        = warm_sr[SYNC_STAGES-1];
    assign rise        = (clk_hist == 2'b01);
    assign fall        = (clk_hist == 2'b10);
    assign load_word   = frame_of(ACTIVE_CH ? CH1_DATA : CH0_DATA);
    assign reload_word = frame_of(ctrl_sr[3] ? CH1_DATA : CH0_DATA);

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            clk_sync <= '0;
            csn_sync <= '1;
            sdi_sync <= '0;
            warm_sr  <= '0;
            clk_hist <= 2'b00;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ser_clk};
            csn_sync <= {csn_sync[SYNC_STAGES-2:0], CSN};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            warm_sr  <= {warm_sr[SYNC_STAGES-2:0], 1'b1};
            clk_hist <= {clk_hist[0], clk_sync[SYNC_STAGES-1]};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state       <= IDLE;
            SDO         <= 1'b0;
            SDO_OE      <= 1'b0;
            CTRL_WORD   <= '0;
            CTRL_VALID  <= 1'b0;
            FRAME_DONE  <= 1'b0;
            FRAME_ERR   <= 1'b0;
            ACTIVE_CH   <= 1'b0;
            bit_ctr     <= '0;
            frame_sr    <= '0;
            ctrl_sr     <= '0;
            armed       <= 1'b0;
            reload_pend <= 1'b0;
        end else begin
            CTRL_VALID <= 1'b0;
            FRAME_DONE <= 1'b0;
            FRAME_ERR  <= 1'b0;
            unique case (state)
                IDLE: begin
                    SDO    <= 1'b0;
                    SDO_OE <= 1'b0;
                    // A start needs a real high level seen first, so a CSN
                    // already low at reset release or enable is not a start.
                    if (csn_s) begin
                        armed <= warm;
                    end else if (!en) begin
                        armed <= 1'b0;
                    end else if (armed) begin
                        armed <= 1'b0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    frame_sr    <= load_word;
                    SDO         <= load_word[FRAME_W-1];
                    SDO_OE      <= 1'b1;
                    bit_ctr     <= '0;
                    reload_pend <= 1'b0;
                    state       <= SHIFT;
                end
                SHIFT: begin
                    if (csn_s) begin
                        bit_ctr     <= '0;
                        reload_pend <= 1'b0;
                        if (bit_ctr != '0) begin
                            FRAME_ERR <= 1'b1;
                            state     <= ABORT;
                        end else begin
                            SDO    <= 1'b0;
                            SDO_OE <= 1'b0;
                            state  <= IDLE;
                        end
                    end else if (rise) begin
                        if (bit_ctr == LAST_BIT) begin
                            FRAME_DONE  <= 1'b1;
                            CTRL_VALID  <= 1'b1;
                            CTRL_WORD   <= ctrl_sr;
                            ACTIVE_CH   <= ctrl_sr[3];
                            bit_ctr     <= '0;
                            frame_sr    <= reload_word;
                            reload_pend <= 1'b1;
                        end else begin
                            bit_ctr <= bit_ctr + CW'(1);
                            if (bit_ctr < CTRL_BITS)
                                ctrl_sr <= {ctrl_sr[BYTE_W-2:0], sdi_s};
                        end
                    end else if (fall) begin
                        // The fall after a back-to-back reload presents the new MSB.
                        if (reload_pend) begin
                            SDO         <= frame_sr[FRAME_W-1];
                            reload_pend <= 1'b0;
                        end else if (bit_ctr != '0) begin
                            frame_sr <= frame_sr << 1;
                            SDO      <= frame_sr[FRAME_W-2];
                        end
                    end
                end
                ABORT: begin
                    SDO    <= 1'b0;
                    SDO_OE <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
